fp16_mul_pipe: RTL and testbench

//  Pipelined IEEE-754 binary16 multiplier; direct consumer of the operand register stage.
//  - Takes the registered operand pair (reg_a/reg_b) and its write_en strobe.
//  - Returns a rounded fp16 product 3 cycles later, with ready/valid backpressure.
//  - First arithmetic stage of the DL_float datapath; feeds accumulate/activation blocks.

---
 rtl/fp16_mul_pipe_if.sv | 24 ++
 rtl/fp16_mul_pipe.sv | 135 +++++++++++++
 tb/tb_fp16_mul_pipe.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_mul_pipe_if.sv
// fp16_mul_pipe_if: operand/result handshake bundle; flag ports exist only with FP16_MUL_FLAGS_EN
interface fp16_mul_pipe_if #(parameter int DW = 16);
  logic          in_valid;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
`ifdef FP16_MUL_FLAGS_EN
  logic [2:0]    flags;
  logic [2:0]    sticky;
  logic          flag_clr;
  modport slave  (input in_valid, op_a, op_b, out_ready, flag_clr,
                  output in_ready, out_valid, result, flags, sticky);
  modport master (output in_valid, op_a, op_b, out_ready, flag_clr,
                  input in_ready, out_valid, result, flags, sticky);
`else
  modport slave  (input in_valid, op_a, op_b, out_ready,
                  output in_ready, out_valid, result);
  modport master (output in_valid, op_a, op_b, out_ready,
                  input in_ready, out_valid, result);
`endif
endinterface

// File: rtl/fp16_mul_pipe.sv
// fp16_mul_pipe: 3-stage binary16 multiplier (FTZ, RNE) with ready/valid; FP16_MUL_FLAGS_EN adds flags/sticky
module fp16_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic clk,
  input logic rst,
  fp16_mul_pipe_if.slave bus
);
  localparam int DW   = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = MAN_W + 1;
  localparam int PW   = 2 * MW;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [1:0] K_NUM = 2'd0, K_NAN = 2'd1, K_INF = 2'd2, K_ZERO = 2'd3;
  localparam logic [DW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  logic v1_q, v2_q, v3_q;
  logic s1_sign_q, s2_sign_q;
  logic [1:0] s1_kind_q, s2_kind_q;
  logic signed [EW-1:0] s1_e_q, s2_e_q;
  logic [MW-1:0] s1_ma_q, s1_mb_q;
  logic [PW-1:0] s2_p_q;
  logic [DW-1:0] res_q;

  assign adv           = !(v3_q && !bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.result    = res_q;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_z, b_z, a_nan, b_nan, a_inf, b_inf;
  logic [1:0] kind_d;
  logic signed [EW-1:0] e1_d;

  // S1: unpack and classify; subnormals count as zero
  always_comb begin
    ea     = bus.op_a[DW-2 -: EXP_W];
    eb     = bus.op_b[DW-2 -: EXP_W];
    fa     = bus.op_a[MAN_W-1:0];
    fb     = bus.op_b[MAN_W-1:0];
    a_z    = ~|ea;
    b_z    = ~|eb;
    a_nan  = &ea && |fa;
    b_nan  = &eb && |fb;
    a_inf  = &ea && ~|fa;
    b_inf  = &eb && ~|fb;
    kind_d = (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) ? K_NAN :
             (a_inf || b_inf) ? K_INF : (a_z || b_z) ? K_ZERO : K_NUM;
    e1_d   = EW'(ea) + EW'(eb) - EW'(BIAS);
  end

  logic top, guard, stk, up, carry, of, uf;
  logic [MAN_W-1:0] man, man_r;
  logic signed [EW-1:0] en, er;
  logic [DW-1:0] inf_v, zero_v, res_d;

  // S3: normalize by one, round to nearest even, then resolve specials/overflow/underflow
  always_comb begin
    top            = s2_p_q[PW-1];
    man            = top ? s2_p_q[PW-2 -: MAN_W] : s2_p_q[PW-3 -: MAN_W];
    guard          = top ? s2_p_q[PW-2-MAN_W] : s2_p_q[PW-3-MAN_W];
    stk            = top ? |s2_p_q[PW-3-MAN_W:0] : |s2_p_q[PW-4-MAN_W:0];
    up             = guard && (stk || man[0]);
    {carry, man_r} = {1'b0, man} + {{MAN_W{1'b0}}, up};
    en             = s2_e_q + {{(EW-1){1'b0}}, top};
    er             = en + {{(EW-1){1'b0}}, carry};
    uf             = en[EW-1] || en == '0;
    of             = er >= EMAX;
    inf_v          = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    zero_v         = {s2_sign_q, {(DW-1){1'b0}}};
    res_d          = s2_kind_q == K_NAN ? QNAN : s2_kind_q == K_INF ? inf_v :
                     s2_kind_q == K_ZERO ? zero_v : of ? inf_v : uf ? zero_v :
                     {s2_sign_q, er[EXP_W-1:0], man_r};
  end

  // Stage valids and output word: async clear, everything advances together unless stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      res_q <= '0;
    end else if (adv) begin
      v1_q  <= bus.in_valid;
      v2_q  <= v1_q;
      v3_q  <= v2_q;
      res_q <= res_d;
    end
  end

  // Stage payloads: qualified by the valids, so they need no reset
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q <= bus.op_a[DW-1] ^ bus.op_b[DW-1];
      s1_kind_q <= kind_d;
      s1_e_q    <= e1_d;
      s1_ma_q   <= {1'b1, fa};
      s1_mb_q   <= {1'b1, fb};
      s2_sign_q <= s1_sign_q;
      s2_kind_q <= s1_kind_q;
      s2_e_q    <= s1_e_q;
      s2_p_q    <= PW'(s1_ma_q) * PW'(s1_mb_q);
    end
  end

`ifdef FP16_MUL_FLAGS_EN
  logic [2:0] flags_d, flags_q, sticky_d, sticky_q;
  logic take;

  // Exception flags {invalid, overflow, underflow} and their sticky accumulation
  always_comb begin
    flags_d  = {s2_kind_q == K_NAN, s2_kind_q == K_NUM && of, s2_kind_q == K_NUM && !of && uf};
    take     = v3_q && bus.out_ready;
    sticky_d = bus.flag_clr ? (take ? flags_q : 3'b000) : (take ? sticky_q | flags_q : sticky_q);
  end

  // Flag registers follow the result word; sticky is cleared synchronously by flag_clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q  <= '0;
      sticky_q <= '0;
    end else begin
      if (adv) flags_q <= flags_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.flags  = flags_q;
  assign bus.sticky = sticky_q;
`endif
endmodule

// File: tb/tb_fp16_mul_pipe.sv
// tb_fp16_mul_pipe: scoreboard bench for fp16_mul_pipe (flag checks with FP16_MUL_FLAGS_EN)
module tb_fp16_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp16_mul_pipe_if bus ();
  fp16_mul_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;
  logic [18:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {invalid, overflow, underflow, result}
  function automatic logic [18:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic s, an, bn, ai, bi, az, bz;
    int ea, eb, fa, fb, p, e, sh, q, rem, half;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    fa = int'(a[9:0]);
    fb = int'(b[9:0]);
    an = ea == 31 && fa != 0;
    bn = eb == 31 && fb != 0;
    ai = ea == 31 && fa == 0;
    bi = eb == 31 && fb == 0;
    az = ea == 0;
    bz = eb == 0;
    if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 16'h7E00};
    if (ai || bi) return {3'b000, s, 5'h1F, 10'h0};
    if (az || bz) return {3'b000, s, 15'h0};
    p  = (1024 + fa) * (1024 + fb);
    sh = (p >= (1 << 21)) ? 11 : 10;
    e  = ea + eb - 15 + sh - 10;
    if (e <= 0) return {3'b001, s, 15'h0};
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) return {3'b010, s, 5'h1F, 10'h0};
    return {3'b000, s, 5'(e), 10'(q)};
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    if (rst) begin
      if (bus.in_valid && bus.in_ready) sb.push_back(ref_mul(bus.op_a, bus.op_b));
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          logic [18:0] e;
          e = sb.pop_front();
          n_pop++;
          chk("result", bus.result, e[15:0]);
`ifdef FP16_MUL_FLAGS_EN
          chk("flags", bus.flags, e[18:16]);
`endif
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  task automatic latency(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    @(negedge clk);
    chk("lat_accept", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_c2", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_c3", bus.out_valid, 1);
    chk("lat_res", bus.result, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int p0;
    logic done;
    logic [15:0] a, b;
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.out_ready = 1'b1;
`ifdef FP16_MUL_FLAGS_EN
    bus.flag_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_res", bus.result, 0);
`ifdef FP16_MUL_FLAGS_EN
    chk("rst_flags", bus.flags, 0);
    chk("rst_sticky", bus.sticky, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;

    latency(16'h3C00, 16'h3C00, 16'h3C00);
    chk("ref_neg", ref_mul(16'h4000, 16'hC200), {3'b000, 16'hC600});
    chk("ref_rne", ref_mul(16'h3C01, 16'h3C01), {3'b000, 16'h3C02});
    chk("ref_ovf", ref_mul(16'h7BFF, 16'h7BFF), {3'b010, 16'h7C00});
    chk("ref_inv", ref_mul(16'h7C00, 16'h0000), {3'b100, 16'h7E00});
    chk("ref_ftz", ref_mul(16'h0001, 16'h3C00), {3'b000, 16'h0000});
    send(16'h4000, 16'hC200);
    send(16'h3C01, 16'h3C01);
    send(16'h7BFF, 16'h7BFF);
    send(16'h7C00, 16'h0000);
    send(16'h0001, 16'h3C00);
    send(16'h7E00, 16'h3C00);
    send(16'hFC00, 16'h4000);
    send(16'h8000, 16'h4500);
    send(16'h0400, 16'h0400);
    send(16'h3BFF, 16'h3C01);
    drain();
`ifdef FP16_MUL_FLAGS_EN
    chk("sticky_acc", bus.sticky, 3'b111);
    bus.flag_clr = 1'b1;
    @(posedge clk);
    #1 bus.flag_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr", bus.sticky, 0);
`endif

    p0 = n_pop;
    fork
      for (int i = 0; i < 8; i++) send(16'h3C00 + 16'(i * 64), 16'h4000 + 16'(i));
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_ov", bus.out_valid, 1);
        chk("stall_ir", bus.in_ready, 0);
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_cnt", n_pop - p0, 8);

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          a = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
          b = ($urandom_range(0, 7) == 0) ? 16'($urandom) : {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
          send(a, b);
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1 bus.out_ready = 1'($urandom_range(0, 1));
      end
    join
    bus.out_ready = 1'b1;
    drain();

    bus.out_ready = 1'b0;
    send(16'h4000, 16'h4000);
    send(16'h4200, 16'h4000);
    send(16'h3C00, 16'h4400);
    #2 rst = 1'b0;
    #1;
    chk("arst_ov", bus.out_valid, 0);
    chk("arst_res", bus.result, 0);
    chk("arst_ir", bus.in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    latency(16'h4000, 16'h4000, 16'h4400);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
